bcd_down_timer: RTL

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

---
 rtl/bcd_down_timer_pkg.sv | 17 +
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_down_timer.sv | 101 ++++++++++
 3 files changed

// File: rtl/bcd_down_timer_pkg.sv
// Shared definitions for the BCD counter family: FSM encodings, digit limit
// and the digit clamp applied on load.
package bcd_down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrement: subtracts the incoming borrow, wrapping 0 to 9
// and raising a borrow to the next digit when it does.
module bcd_digit_dec
    import bcd_down_timer_pkg::*;
(
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);

    always_comb begin
        q    = d;
        bout = 1'b0;
        if (bin) begin
            if (d == 4'd0) begin
                q    = BCD_MAX;
                bout = 1'b1;
            end else begin
                q = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down timer, falling-edge clocked, with optional auto-reload
// of the last loaded value on expiry.
module bcd_down_timer
    import bcd_down_timer_pkg::*;
#(
    parameter int unsigned RELOAD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       en,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [7:0] reload_q, reload_d;
    logic       done_q, done_d;

    logic [3:0] ones_dec, tens_dec;
    logic       ones_borrow, tens_borrow;

    bcd_digit_dec u_ones_dec (
        .d    (ones_q),
        .bin  (1'b1),
        .q    (ones_dec),
        .bout (ones_borrow)
    );

    bcd_digit_dec u_tens_dec (
        .d    (tens_q),
        .bin  (ones_borrow),
        .q    (tens_dec),
        .bout (tens_borrow)
    );

    always_comb begin
        state_d  = state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            tens_d   = bcd_clamp(din[7:4]);
            ones_d   = bcd_clamp(din[3:0]);
            reload_d = {tens_d, ones_d};
            state_d  = ({tens_d, ones_d} != 8'h00) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: ;
                RUN: begin
                    if (en) begin
                        if (tens_q == 4'd0 && ones_q == 4'd1) begin
                            done_d = 1'b1;
                            if (RELOAD != 0) begin
                                tens_d = reload_q[7:4];
                                ones_d = reload_q[3:0];
                            end else begin
                                tens_d  = 4'd0;
                                ones_d  = 4'd0;
                                state_d = DONE;
                            end
                        end else if (!tens_borrow) begin
                            // Guard: never underflow past 00 even if state is corrupted
                            tens_d = tens_dec;
                            ones_d = ones_dec;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            reload_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
